// File: rtl/bitwise_rr_sched.sv
// bitwise_rr_sched: round-robin share of one AND/ORR/EOR/BIC unit between two requesters, with a one-entry result buffer and N/Z flags.
// Define BITWISE_RR_STATS_EN to add per-requester saturating accept counters (gnt_cnt0/gnt_cnt1, clr_stats).
module bitwise_rr_sched #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_s,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_o,
  output logic             res_id,
  output logic             res_n,
  output logic             res_z,
`ifdef BITWISE_RR_STATS_EN
  output logic [15:0]      gnt_cnt0,
  output logic [15:0]      gnt_cnt1,
  input  logic             clr_stats,
`endif
  output logic             flag_n,
  output logic             flag_z
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, id_q, id_d, n_q, n_d, z_q, z_d, fn_q, fn_d, fz_q, fz_d;
  logic gnt, accept, s_sel;
  logic [1:0] op_sel;
  logic [WIDTH-1:0] a_sel, b_sel, alu, res_q, res_d;
  // Ties go to the requester that was not served last; ready is masked during reset.
  assign gnt = (req0_valid & req1_valid) ? ~last_q : req1_valid;
  assign accept = ~rst & (req0_valid | req1_valid) & (state_q == EMPTY | res_ready);
  assign req0_ready = accept & ~gnt;
  assign req1_ready = accept & gnt;
  assign op_sel = gnt ? req1_op : req0_op;
  assign a_sel = gnt ? req1_a : req0_a;
  assign b_sel = gnt ? req1_b : req0_b;
  assign s_sel = gnt ? req1_s : req0_s;
  always_comb begin
    alu = op_sel == 2'b00 ? a_sel & b_sel :
          op_sel == 2'b01 ? a_sel | b_sel :
          op_sel == 2'b10 ? a_sel ^ b_sel : a_sel & ~b_sel;
    state_d = accept ? FULL : (res_ready ? EMPTY : state_q);
    last_d = accept ? gnt : last_q;
    res_d = accept ? alu : res_q;
    id_d = accept ? gnt : id_q;
    n_d = accept ? alu[WIDTH-1] : n_q;
    z_d = accept ? ~|alu : z_q;
    fn_d = (accept & s_sel) ? alu[WIDTH-1] : fn_q;
    fz_d = (accept & s_sel) ? ~|alu : fz_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q <= 1'b1;
      res_q <= '0;
      id_q <= 1'b0;
      n_q <= 1'b0;
      z_q <= 1'b0;
      fn_q <= 1'b0;
      fz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      res_q <= res_d;
      id_q <= id_d;
      n_q <= n_d;
      z_q <= z_d;
      fn_q <= fn_d;
      fz_q <= fz_d;
    end
  end
  assign res_valid = state_q == FULL;
  assign res_o = res_q;
  assign res_id = id_q;
  assign res_n = n_q;
  assign res_z = z_q;
  assign flag_n = fn_q;
  assign flag_z = fz_q;
`ifdef BITWISE_RR_STATS_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    cnt0_d = clr_stats ? 16'd0 : (req0_ready && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
    cnt1_d = clr_stats ? 16'd0 : (req1_ready && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= 16'd0;
      cnt1_q <= 16'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif
endmodule

// File: tb/tb_bitwise_rr_sched.sv
// tb_bitwise_rr_sched: directed vector table plus hand sequences for reset, round-robin, back-pressure and stats.
module tb_bitwise_rr_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid, req0_ready, req0_s, req1_valid, req1_ready, req1_s;
  logic [1:0] req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, res_o;
  logic res_valid, res_ready, res_id, res_n, res_z, flag_n, flag_z;
`ifdef BITWISE_RR_STATS_EN
  logic [15:0] gnt_cnt0, gnt_cnt1;
  logic clr_stats = 1'b0;
`endif
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  bitwise_rr_sched #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_s(req0_s),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_s(req1_s),
    .res_valid(res_valid), .res_ready(res_ready), .res_o(res_o), .res_id(res_id),
    .res_n(res_n), .res_z(res_z),
`ifdef BITWISE_RR_STATS_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .clr_stats(clr_stats),
`endif
    .flag_n(flag_n), .flag_z(flag_z)
  );
  typedef struct {
    logic id;
    logic [1:0] op;
    logic [31:0] a, b;
    logic s;
    logic [31:0] r;
    logic n, z, fn, fz;
  } vec_t;
  vec_t vecs[8];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask
  task automatic drive(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_s = s;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_s = s;
    end
  endtask
  initial begin
    vecs[0] = '{1'b0, 2'b10, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 2'b01, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 2'b11, 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b1, 32'hFFFF_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'b00, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 2'b00, 32'h1234_5678, 32'hFFFF_0000, 1'b1, 32'h1234_0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 2'b10, 32'h0000_FFFF, 32'hFFFF_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 2'b01, 32'h0000_0000, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 2'b11, 32'h0000_5555, 32'h0000_5555, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    req0_op = 2'b00; req0_a = '0; req0_b = '0; req0_s = 1'b0;
    req1_op = 2'b00; req1_a = '0; req1_b = '0; req1_s = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_flags", {flag_n, flag_z}, 0);
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    // Hold a flag-setting result in the buffer, then reset asynchronously mid-cycle.
    res_ready = 1'b0;
    drive(1'b0, 2'b01, 32'h8000_0000, 32'h0, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("prime_valid", res_valid, 1);
    chk("prime_flag_n", flag_n, 1);
    @(negedge clk); #1;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("async_rst_res", {res_valid, res_o, res_id, res_n, res_z}, 0);
    chk("async_rst_flags", {flag_n, flag_z}, 0);
    chk("async_rst_ready", {req0_ready, req1_ready}, 0);
    @(negedge clk);
    rst = 1'b0; res_ready = 1'b1;
    #1;
    chk("tie_ready0", req0_ready, 1);
    chk("tie_ready1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_res_id", res_id, 0);
    chk("tie_res_o", res_o, 32'h8000_0000);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s);
      #1;
      chk($sformatf("v%0d_ready", i), {req1_ready, req0_ready}, vecs[i].id ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk($sformatf("v%0d_res_o", i), res_o, vecs[i].r);
      chk($sformatf("v%0d_id_nz", i), {res_valid, res_id, res_n, res_z}, {1'b1, vecs[i].id, vecs[i].n, vecs[i].z});
      chk($sformatf("v%0d_flags", i), {flag_n, flag_z}, {vecs[i].fn, vecs[i].fz});
      @(negedge clk);
    end
    // Both requesters held valid: grants alternate starting with 0 (last was 1).
    drive(1'b0, 2'b00, 32'hFFFF_FFFF, 32'h1, 1'b0);
    drive(1'b1, 2'b01, 32'h8000_0000, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt%0d_ready", k), {req1_ready, req0_ready}, (k % 2) ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      chk($sformatf("alt%0d_res", k), {res_id, res_n, res_o}, (k % 2) ? {2'b11, 32'h8000_0000} : {2'b00, 32'h1});
      @(negedge clk);
    end
    chk("alt_flags", {flag_n, flag_z}, 2'b01);
    res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), {req1_ready, req0_ready}, 0);
      chk($sformatf("bp%0d_res", k), {res_valid, res_id, res_o}, {2'b11, 32'h8000_0000});
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", {req1_ready, req0_ready}, 2'b01);
    @(posedge clk); #1;
    chk("bp_release_res", {res_valid, res_id, res_o}, {2'b10, 32'h1});
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", res_valid, 0);
    chk("drain_hold", {res_o, res_n, res_z}, {32'h1, 2'b00});
    chk("drain_flags", {flag_n, flag_z}, 2'b01);
`ifdef BITWISE_RR_STATS_EN
    @(negedge clk);
    rst = 1'b1; #1; rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(k >= 3, 2'b00, 32'h0, 32'h0, 1'b0);
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
    end
    chk("stats_cnt0", gnt_cnt0, 3);
    chk("stats_cnt1", gnt_cnt1, 2);
    drive(1'b0, 2'b00, 32'h0, 32'h0, 1'b0);
    clr_stats = 1'b1;
    @(posedge clk); #1;
    clr_stats = 1'b0; req0_valid = 1'b0;
    chk("stats_clr", {gnt_cnt0, gnt_cnt1}, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bitwise_rr_sched.md
Name: bitwise_rr_sched

Overview:
- Round-robin scheduler that shares one bitwise logic unit (AND/ORR/EOR/BIC with N/Z flag generation) between two requesters.
- Arbitrates valid/ready requests and computes the selected operation.
- Holds the result in a one-entry output buffer with valid/ready back-pressure.
- Owns the architectural N/Z flag register, updated only by flag-setting operations.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  2  00 AND (a&b), 01 ORR (a|b), 10 EOR (a^b), 11 BIC (a&~b).
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_s  in  1  set-flags request.
- req1_valid, req1_ready, req1_op, req1_a, req1_b, req1_s: same as requester 0, for requester 1.
- res_valid  out  1  output buffer holds a result.
- res_ready  in  1  consumer takes the result.
- res_o  out  WIDTH  result.
- res_id  out  1  requester that produced res_o.
- res_n  out  1  result bit WIDTH-1.
- res_z  out  1  1 when res_o == 0 (all WIDTH bits).
- flag_n  out  1  architectural N flag.
- flag_z  out  1  architectural Z flag.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - res_valid=0, res_o=0, res_id=0, res_n=0, res_z=0.
  - flag_n=0, flag_z=0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - A pending unconsumed result is discarded.
  - Both readies 0 while rst is high.
- Buffer FSM, two states:
  - EMPTY (res_valid=0).
  - FULL (res_valid=1).
- can_accept = EMPTY | (FULL & res_ready). Same-cycle drain and refill is allowed, giving full throughput.
- Grant (combinational):
  - Only req0_valid → grant 0.
  - Only req1_valid → grant 1.
  - Both valid → grant the requester ≠ last.
  - Neither valid → no grant.
- reqX_ready = can_accept & grant==X. At most one ready is high per cycle.
  - Ready may depend on valid.
  - A requester must hold valid and its fields stable until its ready.
- On accept (valid & ready at a rising edge):
  - res_o ← op(a,b) of the granted requester.
  - res_id ← granted index.
  - res_n ← result MSB.
  - res_z ← NOR of all result bits.
  - res_valid ← 1.
  - last ← granted index.
- Latency: result visible one cycle after acceptance.
- res_* stay stable while res_valid & ~res_ready.
- Drain without accept: FULL & res_ready & no grant → EMPTY, with res_o/res_n/res_z retaining their values.
- Flags:
  - When the accepted request has s=1, flag_n/flag_z load the new result's N/Z on the same edge as res_o.
  - When s=0, flags hold.
  - Flags never change on drain.
- BIC is a & ~b. EOR result 0 ⇒ Z=1, N=0. No carry or overflow is produced.
- last updates only on an actual accept, not on a grant blocked by back-pressure.

Optional Feature:
- Macro: BITWISE_RR_STATS_EN.
- When defined, add ports:
  - gnt_cnt0  out  16  count of accepts for requester 0.
  - gnt_cnt1  out  16  count of accepts for requester 1.
  - clr_stats  in  1  synchronous clear of both counters.
- Counter rules:
  - Each counter increments on its requester's accept.
  - Counters saturate at 16'hFFFF.
  - Reset value 0.
  - clr_stats has priority over an increment in the same cycle.
- When undefined, none of these ports or counters exist; behaviour is otherwise identical.

Test Plan:
1. Reset asserted mid-transfer with res_valid=1 → outputs immediately 0, flags 0; after release, tie goes to requester 0.
2. req0 EOR a=32'hA5A5_A5A5, b=32'hA5A5_A5A5, s=1; res_ready=1 → next cycle res_o=0, res_z=1, res_n=0, res_id=0, flag_z=1, flag_n=0.
3. Both valid continuously with res_ready=1 → accepts alternate 0,1,0,1, one result per cycle. Requester 1 ORR a=32'h8000_0000, b=0, s=0 → res_n=1, flags unchanged.
4. res_ready=0 with buffer FULL, both valid → no ready for 5 cycles, res_* stable, last unchanged; res_ready=1 → same-cycle drain and accept of the requester not granted last.
5. BIC a=32'hFFFF_FFFF, b=32'h0000_FFFF, s=1 → res_o=32'hFFFF_0000, flag_n=1, flag_z=0. A following AND with s=0 producing 0 → res_z=1, flag_z stays 0.
6. With BITWISE_RR_STATS_EN: 3 accepts on req0, 2 on req1 → gnt_cnt0=3, gnt_cnt1=2; clr_stats asserted together with an accept → both counters 0.
